lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver.sv | 195 +++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Passive HD44780-style LCD bus snooper: synchronizes the bus, qualifies e strobes,
// and mirrors DDRAM writes into a 32-entry character buffer with command decode.
module lcd_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int E_MIN_HIGH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       disp_on,
  output logic       busy,
  output logic       err
);

  localparam int            CW      = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] E_MIN   = CW'(E_MIN_HIGH);
  localparam logic [7:0]    BLANK   = 8'h20;

  // Sync word layout: {rs, rw, e, data[7:0]}
  logic [10:0]   sync_q [SYNC_STAGES];
  logic [10:0]   sync_d [SYNC_STAGES];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_l_q, rs_l_d, rw_l_q, rw_l_d;
  logic [7:0]    data_l_q, data_l_d;
  logic [7:0]    mem_q [32];
  logic [7:0]    mem_d [32];
  logic [7:0]    rd_char_q, rd_char_d;
  logic [4:0]    cursor_q, cursor_d;
  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic          disp_on_q, disp_on_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          id_q, id_d;
  logic          cgram_q, cgram_d;
  logic [4:0]    clr_idx_q, clr_idx_d;
  logic          e_s, acc;

  assign e_s = sync_q[SYNC_STAGES-1][8];
  // Falling edge of a qualified pulse: cnt is nonzero only if e was high last cycle.
  assign acc = !e_s && (cnt_q != '0) && (cnt_q >= E_MIN);

  always_comb begin
    sync_d[0] = {lcd_rs, lcd_rw, lcd_e, lcd_data};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    cnt_d    = '0;
    rs_l_d   = rs_l_q;
    rw_l_d   = rw_l_q;
    data_l_d = data_l_q;
    if (e_s) begin
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      rs_l_d   = sync_q[SYNC_STAGES-1][10];
      rw_l_d   = sync_q[SYNC_STAGES-1][9];
      data_l_d = sync_q[SYNC_STAGES-1][7:0];
    end
  end

  always_comb begin
    mem_d       = mem_q;
    rd_char_d   = mem_q[rd_addr];
    cursor_d    = cursor_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    disp_on_d   = disp_on_q;
    busy_d      = busy_q;
    err_d       = err_q;
    id_d        = id_q;
    cgram_d     = cgram_q;
    clr_idx_d   = clr_idx_q;

    if (busy_q) begin
      mem_d[clr_idx_q] = BLANK;
      if (clr_idx_q == 5'd31) begin
        busy_d    = 1'b0;
        cursor_d  = 5'd0;
        id_d      = 1'b1;
        clr_idx_d = 5'd0;
      end else begin
        clr_idx_d = clr_idx_q + 5'd1;
      end
    end

    if (acc) begin
      if (busy_q || rw_l_q) begin
        err_d = 1'b1;
      end else if (rs_l_q) begin
        if (!cgram_q) begin
          mem_d[cursor_q] = data_l_q;
          wr_valid_d      = 1'b1;
          wr_addr_d       = cursor_q;
          wr_data_d       = data_l_q;
          cursor_d        = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
        end
      end else begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = data_l_q;
        // Decoded by the most significant set bit.
        casez (data_l_q)
          8'b1???????: begin
            cgram_d = 1'b0;
            if (data_l_q[6:4] == 3'b000)      cursor_d = {1'b0, data_l_q[3:0]};
            else if (data_l_q[6:4] == 3'b100) cursor_d = {1'b1, data_l_q[3:0]};
            else                              err_d    = 1'b1;
          end
          8'b01??????: cgram_d   = 1'b1;
          8'b00001???: disp_on_d = data_l_q[2];
          8'b000001??: id_d      = data_l_q[1];
          8'b0000001?: cursor_d  = 5'd0;
          8'b00000001: begin
            busy_d    = 1'b1;
            clr_idx_d = 5'd0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int i = 0; i < 32; i++) mem_q[i] <= BLANK;
      cnt_q       <= '0;
      rs_l_q      <= 1'b0;
      rw_l_q      <= 1'b0;
      data_l_q    <= 8'h00;
      rd_char_q   <= BLANK;
      cursor_q    <= 5'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      disp_on_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      id_q        <= 1'b1;
      cgram_q     <= 1'b0;
      clr_idx_q   <= 5'd0;
    end else begin
      sync_q      <= sync_d;
      mem_q       <= mem_d;
      cnt_q       <= cnt_d;
      rs_l_q      <= rs_l_d;
      rw_l_q      <= rw_l_d;
      data_l_q    <= data_l_d;
      rd_char_q   <= rd_char_d;
      cursor_q    <= cursor_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      disp_on_q   <= disp_on_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      id_q        <= id_d;
      cgram_q     <= cgram_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  assign rd_char   = rd_char_q;
  assign cursor    = cursor_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign disp_on   = disp_on_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives LCD bus strobes and checks
// reports, cursor, flags and buffer contents against hand-computed values.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       disp_on, busy, err;

  int total = 0;
  int bad   = 0;

  logic [4:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] wrd_q[$];
  logic [7:0] cmd_q[$];
  int         busy_cnt = 0;

  lcd_bus_receiver #(.SYNC_STAGES(2), .E_MIN_HIGH(2)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .disp_on(disp_on),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Record one-cycle reports and busy cycles at the falling edge.
  always @(negedge clk) begin
    if (wr_valid) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wrd_q.push_back(rd_char);
    end
    if (cmd_valid) cmd_q.push_back(cmd_code);
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    tick(hi);
    lcd_e = 1'b0;
    tick(6);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick(1);
    check("busy_timeout", busy, 0);
  endtask

  task automatic do_reset();
    lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor", cursor, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_rd_char", rd_char, 8'h20);
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    int base, bc;
    rst = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
    tick(3);
    check("init_rd_char", rd_char, 8'h20);
    check("init_cursor", cursor, 0);
    check("init_wr_valid", wr_valid, 0);
    check("init_cmd_valid", cmd_valid, 0);
    check("init_wr_addr", wr_addr, 0);
    check("init_wr_data", wr_data, 0);
    check("init_cmd_code", cmd_code, 0);
    check("init_busy", busy, 0);
    check("init_err", err, 0);
    check("init_disp_on", disp_on, 0);
    rst = 1'b1;
    tick(2);

    // Clear then two data writes; rd_addr held at 0 to observe read-during-write.
    bc = busy_cnt;
    base = cmd_q.size();
    strobe(1'b0, 1'b0, 8'h01, 4);
    check("clr_cmd_seen", cmd_q.size(), base + 1);
    if (cmd_q.size() > base) check("clr_cmd_code", cmd_q[base], 8'h01);
    wait_idle();
    check("clr_busy_len", busy_cnt - bc, 32);
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h31, 4);
    strobe(1'b1, 1'b0, 8'h32, 4);
    check("s1_nwr", wa_q.size(), base + 2);
    if (wa_q.size() >= base + 2) begin
      check("s1_wa0", wa_q[base], 0);
      check("s1_wd0", wd_q[base], 8'h31);
      check("s1_old_read", wrd_q[base], 8'h20);
      check("s1_wa1", wa_q[base+1], 1);
      check("s1_wd1", wd_q[base+1], 8'h32);
    end
    check("s1_cursor", cursor, 2);
    rd_addr = 5'd1;
    tick(1);
    check("s1_rd1", rd_char, 8'h32);
    check("s1_err", err, 0);

    // Short pulse is ignored.
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h55, 1);
    check("short_nwr", wa_q.size(), base);
    check("short_cursor", cursor, 2);
    check("short_err", err, 0);

    // Line 2 start, 17 writes wrap past 31 to 0.
    strobe(1'b0, 1'b0, 8'hC0, 4);
    check("c0_cursor", cursor, 16);
    base = wa_q.size();
    for (int k = 0; k < 17; k++) strobe(1'b1, 1'b0, 8'h41, 4);
    check("wrap_nwr", wa_q.size(), base + 17);
    if (wa_q.size() >= base + 17)
      for (int k = 0; k < 17; k++) check("wrap_addr", wa_q[base+k], (16 + k) % 32);
    check("wrap_cursor", cursor, 1);
    check("wrap_err", err, 0);

    // Decrement mode wraps 0 -> 31.
    strobe(1'b0, 1'b0, 8'h04, 4);
    strobe(1'b0, 1'b0, 8'h80, 4);
    check("dec_home", cursor, 0);
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h58, 4);
    check("dec_nwr", wa_q.size(), base + 1);
    if (wa_q.size() > base) check("dec_addr", wa_q[base], 0);
    check("dec_cursor", cursor, 31);
    strobe(1'b0, 1'b0, 8'h06, 4);

    // Display on, CGRAM write dropped, DDRAM address 5.
    strobe(1'b0, 1'b0, 8'h0C, 4);
    check("disp_on", disp_on, 1);
    strobe(1'b0, 1'b0, 8'h40, 4);
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h1F, 4);
    check("cg_drop_nwr", wa_q.size(), base);
    check("cg_drop_cursor", cursor, 31);
    strobe(1'b0, 1'b0, 8'h85, 4);
    check("ddram85_cursor", cursor, 5);
    strobe(1'b1, 1'b0, 8'h30, 4);
    check("ddram85_nwr", wa_q.size(), base + 1);
    if (wa_q.size() > base) check("ddram85_addr", wa_q[base], 5);
    check("ddram85_cursor2", cursor, 6);
    check("cmd_code_hold", cmd_code, 8'h85);
    rd_addr = 5'd5;
    tick(1);
    check("rd5", rd_char, 8'h30);
    check("cg_err", err, 0);

    // Read strobe sets err without a command report.
    base = cmd_q.size();
    strobe(1'b0, 1'b1, 8'h00, 4);
    check("rw_err", err, 1);
    check("rw_no_cmd", cmd_q.size(), base);
    do_reset();
    rd_addr = 5'd5;
    tick(1);
    check("rst_mem5", rd_char, 8'h20);

    // Bad DDRAM address.
    strobe(1'b0, 1'b0, 8'h90, 4);
    check("bad_addr_err", err, 1);
    check("bad_addr_cursor", cursor, 0);
    do_reset();

    // Strobe during a clear is rejected; clear length unaffected.
    strobe(1'b1, 1'b0, 8'h31, 4);
    bc = busy_cnt;
    strobe(1'b0, 1'b0, 8'h01, 4);
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h77, 4);
    check("busy_strobe_err", err, 1);
    wait_idle();
    check("busy_clr_len", busy_cnt - bc, 32);
    check("busy_no_wr", wa_q.size(), base);
    check("busy_cursor", cursor, 0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick(1);
      check("clr_blank", rd_char, 8'h20);
    end

    // Reset mid-strobe, then a normal write.
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h42; lcd_e = 1'b1;
    tick(3);
    do_reset();
    base = wa_q.size();
    strobe(1'b1, 1'b0, 8'h43, 4);
    check("post_rst_nwr", wa_q.size(), base + 1);
    if (wa_q.size() > base) begin
      check("post_rst_addr", wa_q[base], 0);
      check("post_rst_data", wd_q[base], 8'h43);
    end
    check("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
